ft_replay_ctrl: RTL and testbench

//  - Parametrised recovery controller for the fault-tolerant multi-core system.
//  - It watches the per-core error flags from the voter and halts all cores.
//  - It then replays the register file from a healthy source core into all cores,
//    one address per accepted write.
//  - Adds per-core fault masking, a ready/valid write handshake, optional r0 skip,

---
 rtl/ft_replay_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ft_replay_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_replay_ctrl.sv
// Recovery controller: on a voter mismatch, halt all cores and replay the register file
// from a healthy source core, with fault masking, retry limiting and a sticky failure state.
module ft_replay_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned NUM_REG      = 2**ADDR_WIDTH,
  parameter int unsigned NUM_CORES    = 3,
  parameter int unsigned SKIP_R0      = 1,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned QUIET_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CORES-1:0]         error_i,
  input  logic                         ready_i,
  output logic                         halt_o,
  output logic                         replay_we_o,
  output logic [ADDR_WIDTH-1:0]        replay_addr_o,
  output logic [$clog2(NUM_CORES)-1:0] replay_src_o,
  output logic [NUM_CORES-1:0]         fault_mask_o,
  output logic                         done_o,
  output logic                         fail_o
);

  localparam int unsigned SRC_W     = $clog2(NUM_CORES);
  localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 2);
  localparam int unsigned QUIET_W   = $clog2(QUIET_CYCLES + 1);
  localparam int unsigned START     = (SKIP_R0 != 0) ? 1 : 0;
  localparam int unsigned LAST      = NUM_REG - 1;
  localparam bit          NO_WRITES = (START >= NUM_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_REPLAY,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic                   halt_q, halt_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic [NUM_CORES-1:0]   mask_q, mask_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [QUIET_W-1:0]     quiet_q, quiet_d;

  logic [NUM_CORES-1:0]   mask_or_c;
  logic [NUM_CORES-1:0]   src_onehot_c;
  logic                   src_hit_c;
  logic [RETRY_W-1:0]     retry_inc_c;
  logic                   retry_over_c;

  // Lowest-index core whose bit is clear in the given fault mask.
  function automatic logic [SRC_W-1:0] first_healthy(input logic [NUM_CORES-1:0] m);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!m[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

  assign mask_or_c    = mask_q | error_i;
  assign src_onehot_c = NUM_CORES'(1) << src_q;
  assign src_hit_c    = |(error_i & src_onehot_c);
  assign retry_inc_c  = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);
  assign retry_over_c = retry_inc_c > RETRY_W'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      halt_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      src_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      retry_q <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
      quiet_q <= quiet_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    src_d   = src_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    retry_d = retry_q;
    quiet_d = quiet_q;

    case (state_q)
      S_IDLE: begin
        if (error_i == '0) begin
          if (quiet_q < QUIET_W'(QUIET_CYCLES)) begin
            quiet_d = quiet_q + QUIET_W'(1);
            if (quiet_d == QUIET_W'(QUIET_CYCLES)) retry_d = '0;
          end
        end else begin
          mask_d  = error_i;
          src_d   = first_healthy(error_i);
          quiet_d = '0;
          retry_d = retry_inc_c;
          halt_d  = 1'b1;
          if ((&error_i) || retry_over_c) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_HALT;
          end
        end
      end

      S_HALT, S_REPLAY: begin
        halt_d = 1'b1;
        mask_d = mask_or_c;
        if (src_hit_c) begin
          retry_d = retry_inc_c;
          src_d   = first_healthy(mask_or_c);
        end
        // A source failure outranks a coincident handshake: the replay restarts from START.
        if (src_hit_c && ((&mask_or_c) || retry_over_c)) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else if (src_hit_c || (state_q == S_HALT)) begin
          addr_d = ADDR_WIDTH'(START);
          if (NO_WRITES) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_REPLAY;
            we_d    = 1'b1;
          end
        end else if (we_q && ready_i) begin
          if (addr_q == ADDR_WIDTH'(LAST)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            we_d   = 1'b1;
          end
        end else begin
          we_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_FAIL: begin
        halt_d = 1'b1;
        fail_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign halt_o        = halt_q;
  assign replay_we_o   = we_q;
  assign replay_addr_o = addr_q;
  assign replay_src_o  = src_q;
  assign fault_mask_o  = mask_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;

endmodule

// File: tb/tb_ft_replay_ctrl.sv
// Scoreboard bench for ft_replay_ctrl: stimulus pushes expected writes/done/fail events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ft_replay_ctrl;

  localparam int AW    = 5;
  localparam int NR    = 32;
  localparam int NC    = 3;
  localparam int MAXR  = 3;
  localparam int QC    = 64;
  localparam int START = 1;

  localparam int EV_WR   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_FAIL = 2;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] error_i;
  logic          ready_i;
  logic          halt_o;
  logic          replay_we_o;
  logic [AW-1:0] replay_addr_o;
  logic [1:0]    replay_src_o;
  logic [NC-1:0] fault_mask_o;
  logic          done_o;
  logic          fail_o;

  ft_replay_ctrl #(
    .ADDR_WIDTH(AW), .NUM_REG(NR), .NUM_CORES(NC), .SKIP_R0(1),
    .MAX_RETRY(MAXR), .QUIET_CYCLES(QC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .error_i(error_i), .ready_i(ready_i),
    .halt_o(halt_o), .replay_we_o(replay_we_o), .replay_addr_o(replay_addr_o),
    .replay_src_o(replay_src_o), .fault_mask_o(fault_mask_o),
    .done_o(done_o), .fail_o(fail_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int src;
    int mask;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks;
  int  errors;
  int  cyc_cnt;
  bit  fail_mode;
  bit  fail_prev;
  bit  rst_pend;
  bit  end_req;
  bit  end_done;

  // Reference model state: retry count, quiet count, ready toggle phase.
  int  m_retry;
  int  m_quiet;
  bit  tog;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- monitor / checker ----------------
  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic pop_chk(input int kind, input int addr, input int src, input int mask);
    ev_t e;
    chk(exp_q.size() != 0, "event_expected",
        $sformatf("DUT presented kind %0d addr %0d src %0d mask %b, none required", kind, addr, src, mask));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (kind)
        EV_WR: chk(e.kind == EV_WR && e.addr == addr && e.src == src, "write",
                   $sformatf("got write addr %0d src %0d, required kind %0d addr %0d src %0d",
                             addr, src, e.kind, e.addr, e.src));
        EV_DONE: chk(e.kind == EV_DONE && e.mask == mask && e.cyc == cyc_cnt, "done",
                     $sformatf("got done mask %b cycle %0d, required kind %0d mask %b cycle %0d",
                               mask, cyc_cnt, e.kind, e.mask[NC-1:0], e.cyc));
        default: chk(e.kind == EV_FAIL && e.mask == mask, "fail_entry",
                     $sformatf("got fail mask %b, required kind %0d mask %b", mask, e.kind, e.mask[NC-1:0]));
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_pend)
      chk({halt_o, replay_we_o, done_o, fail_o} == 4'b0000 && replay_addr_o == '0 &&
          replay_src_o == '0 && fault_mask_o == '0, "reset_state",
          $sformatf("got halt %b we %b done %b fail %b addr %0d src %0d mask %b, required all 0",
                    halt_o, replay_we_o, done_o, fail_o, replay_addr_o, replay_src_o, fault_mask_o));
    if (rst_n && replay_we_o && ready_i)
      pop_chk(EV_WR, int'(replay_addr_o), int'(replay_src_o), int'(fault_mask_o));
    if (done_o)
      pop_chk(EV_DONE, int'(replay_addr_o), int'(replay_src_o), int'(fault_mask_o));
    if (fail_o && !fail_prev) begin
      pop_chk(EV_FAIL, int'(replay_addr_o), int'(replay_src_o), int'(fault_mask_o));
      fail_mode = 1'b1;
    end
    if (fail_mode)
      chk(halt_o && fail_o && !replay_we_o && !done_o, "fail_hold",
          $sformatf("got halt %b fail %b we %b done %b, required 1 1 0 0",
                    halt_o, fail_o, replay_we_o, done_o));
    fail_prev = fail_o;
    rst_pend  = !rst_n;
    if (!rst_n) fail_mode = 1'b0;
    if (end_req && !end_done) begin
      chk(exp_q.size() == 0, "queue_drained",
          $sformatf("got %0d outstanding expected events, required 0", exp_q.size()));
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus + reference model ----------------
  function automatic int lowest_zero(input int m);
    for (int i = 0; i < NC; i++) if (m[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready(input int rmode);
    case (rmode)
      0:       ready_i = 1'b1;
      1:       begin ready_i = tog; tog = !tog; end
      default: ready_i = ($urandom_range(0, 99) < 60);
    endcase
  endtask

  task automatic push(input int kind, input int addr, input int src, input int mask, input int cyc);
    ev_t e;
    e.kind = kind; e.addr = addr; e.src = src; e.mask = mask; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    error_i = '0;
    for (int i = 0; i < n; i++) begin
      drive_ready(2);
      tick();
      m_quiet = (m_quiet < QC) ? m_quiet + 1 : QC;
      if (m_quiet == QC) m_retry = 0;
    end
  endtask

  task automatic hold(input int n);
    error_i = '0;
    for (int i = 0; i < n; i++) begin
      drive_ready(2);
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; error_i = '0; ready_i = 1'b0;
    tick();
    rst_n = 1'b1;
    m_retry = 0;
    m_quiet = 0;
  endtask

  // One recovery episode; inj_at/rst_at count accepted writes, -1 disables.
  task automatic recover(input int mask, input int rmode, input int inj_at, input int inj_mask,
                         input int rst_at, output bit failed);
    int m, src, addr, nw, err_edge;
    bit injected;
    failed   = 1'b0;
    m        = mask;
    src      = lowest_zero(m);
    m_retry  = (m_retry < 7) ? m_retry + 1 : 7;
    m_quiet  = 0;
    err_edge = cyc_cnt + 1;
    error_i  = NC'(mask);
    drive_ready(rmode);
    if (src < 0 || m_retry > MAXR) begin
      push(EV_FAIL, 0, 0, m, 0);
      tick();
      error_i = '0;
      failed  = 1'b1;
      return;
    end
    tick();
    error_i = '0;
    drive_ready(rmode);
    tick();
    addr = START; nw = 0; injected = 1'b0; tog = 1'b1;
    while (1) begin
      if (nw == rst_at) begin
        do_reset();
        return;
      end
      if (!injected && nw == inj_at) begin
        injected = 1'b1;
        error_i  = NC'(inj_mask);
        ready_i  = 1'b0;
        m        = m | inj_mask;
        if (((inj_mask >> src) & 1) != 0) begin
          src     = lowest_zero(m);
          m_retry = (m_retry < 7) ? m_retry + 1 : 7;
          if (src < 0 || m_retry > MAXR) begin
            push(EV_FAIL, 0, 0, m, 0);
            tick();
            error_i = '0;
            failed  = 1'b1;
            return;
          end
          addr = START;
        end
        tick();
        error_i = '0;
      end else begin
        drive_ready(rmode);
        if (ready_i) begin
          push(EV_WR, addr, src, m, 0);
          // Uninterrupted, always-ready recovery: done lands 1 + (NR-START) edges after sampling.
          if (addr == NR - 1)
            push(EV_DONE, 0, 0, m, (rmode == 0 && inj_at < 0) ? err_edge + 1 + (NR - START) : cyc_cnt + 1);
        end
        tick();
        if (ready_i) begin
          nw++;
          if (addr == NR - 1) break;
          addr++;
        end
      end
    end
    drive_ready(rmode);
    tick();
  endtask

  initial begin
    bit f;
    int r, inj_at, inj_mask;
    int seq_masks[4];
    seq_masks[0] = 1; seq_masks[1] = 2; seq_masks[2] = 4; seq_masks[3] = 1;
    rst_n = 1'b0; error_i = '0; ready_i = 1'b0; tog = 1'b1;
    tick();
    tick();
    rst_n = 1'b1; m_retry = 0; m_quiet = 0;
    idle(3);

    recover(1, 0, -1, 0, -1, f);             // single fault, always ready
    idle(QC + 2);
    recover(1, 1, -1, 0, -1, f);             // ready toggling
    idle(QC + 2);
    recover(4, 2, 12, 2, -1, f);             // non-source fault mid-replay
    idle(QC + 2);
    recover(4, 2, 12, 1, -1, f);             // source fault mid-replay -> restart
    idle(QC + 2);

    recover(7, 2, -1, 0, -1, f);             // all cores faulty
    hold(100);
    do_reset();
    idle(3);

    for (int i = 0; i < 4; i++) begin        // 63 quiet cycles: 4th recovery fails
      recover(seq_masks[i], 0, -1, 0, -1, f);
      if (f) break;
      idle(QC - 1);
    end
    hold(5);
    do_reset();
    idle(3);
    for (int i = 0; i < 4; i++) begin        // 64 quiet cycles: never fails
      recover(seq_masks[i], 0, -1, 0, -1, f);
      idle(QC);
    end

    recover(2, 0, -1, 0, 9, f);              // reset while address 10 is presented
    idle(3);
    recover(1, 0, -1, 0, -1, f);
    idle(QC + 2);

    for (int k = 0; k < 8; k++) begin
      r        = $urandom_range(1, 6);
      inj_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1;
      inj_mask = 1 << $urandom_range(0, NC - 1);
      recover(r, 2, inj_at, inj_mask, -1, f);
      if (f) begin
        hold(3);
        do_reset();
      end
      idle(QC + 2);
    end

    end_req = 1'b1;
    wait (end_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
